// File: rtl/idct_pkg.sv
// Shared definitions for the 8-point 1-D IDCT MAC engine: widths, cosine table,
// rounding constant, output saturation and FSM state type.
package idct_pkg;

    localparam int unsigned IDCT_IN_W   = 12;
    localparam int unsigned IDCT_COEF_W = 8;
    localparam int unsigned IDCT_SHIFT  = 7;
    localparam int unsigned IDCT_OUT_W  = 9;
    localparam int unsigned ACC_W       = IDCT_IN_W + IDCT_COEF_W + 3;

    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(2 ** (IDCT_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (IDCT_OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (IDCT_OUT_W - 1)));

    typedef logic signed [IDCT_COEF_W-1:0] coef_t;

    typedef enum logic {
        StAccum,
        StDone
    } state_e;

    // Row k, column n: round(128 * c(k) * cos((2n+1)k*pi/16))
    localparam coef_t COEF_TBL [8][8] = '{
        '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45,  8'sd45},
        '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12, -8'sd12, -8'sd36, -8'sd53, -8'sd63},
        '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59, -8'sd59, -8'sd24,  8'sd24,  8'sd59},
        '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36,  8'sd36,  8'sd63,  8'sd12, -8'sd53},
        '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45,  8'sd45, -8'sd45, -8'sd45,  8'sd45},
        '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53, -8'sd53, -8'sd12,  8'sd63, -8'sd36},
        '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24, -8'sd24,  8'sd59, -8'sd59,  8'sd24},
        '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63,  8'sd63, -8'sd53,  8'sd36, -8'sd12}
    };

    function automatic coef_t idct_coef(input logic [2:0] k, input logic [2:0] n);
        return COEF_TBL[k][n];
    endfunction

    function automatic logic signed [IDCT_OUT_W-1:0] sat_out(
        input logic signed [ACC_W-1:0] v
    );
        if (v > SAT_MAX) begin
            return SAT_MAX[IDCT_OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[IDCT_OUT_W-1:0];
        end
        return v[IDCT_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/idct_1d_mac_lane.sv
// One IDCT output lane: signed accumulator with multiply-add enable and clear.
module idct_1d_mac_lane #(
    parameter int unsigned IN_W   = 12,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned ACC_W  = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_i,
    input  logic                    en_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic signed [IN_W-1:0]   din_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] prod;

    // Both operands sign-extended before the multiply so the product is full precision
    assign prod = ACC_W'(coef_i) * ACC_W'(din_i);

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/idct_1d_mac.sv
// 8-point 1-D inverse DCT: one coefficient per beat broadcast to 8 MAC lanes,
// then round/shift/saturate into a valid/ready output register.
module idct_1d_mac import idct_pkg::*; #(
    parameter int unsigned IN_W   = IDCT_IN_W,
    parameter int unsigned COEF_W = IDCT_COEF_W,
    parameter int unsigned SHIFT  = IDCT_SHIFT,
    parameter int unsigned OUT_W  = IDCT_OUT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_coef,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*OUT_W-1:0] out_data
);

    state_e             state_q, state_d;
    logic [2:0]         k_q, k_d;
    logic               out_valid_q, out_valid_d;
    logic [8*OUT_W-1:0] out_data_q, out_data_d;
    logic               accept;
    logic               load;

    logic signed [ACC_W-1:0] acc [8];
    logic signed [ACC_W-1:0] rnd [8];
    logic [8*OUT_W-1:0]      sat_vec;

    for (genvar n = 0; n < 8; n++) begin : g_lane
        idct_1d_mac_lane #(
            .IN_W  (IN_W),
            .COEF_W(COEF_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clear_i(load),
            .en_i   (accept),
            .coef_i (idct_coef(k_q, 3'(n))),
            .din_i  (in_coef),
            .acc_o  (acc[n])
        );

        // Add-half then arithmetic shift: round half toward +inf
        assign rnd[n] = (acc[n] + ROUND_C) >>> SHIFT;
    end

    always_comb begin
        sat_vec = '0;
        for (int n = 0; n < 8; n++) begin
            sat_vec[n*OUT_W +: OUT_W] = sat_out(rnd[n]);
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        in_ready = 1'b0;
        accept   = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            StAccum: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept = 1'b1;
                    k_d    = k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!out_valid_q || out_ready) begin
                    load    = 1'b1;
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = sat_vec;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StAccum;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_idct_1d_mac.sv
// Self-checking bench for idct_1d_mac: transaction-level reference model with a
// real-valued cosine table, per-cycle compare, directed and random vectors.
module tb_idct_1d_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_coef;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_data;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_acc = 0;

    int itab [8][8];

    // Reference model state
    int          mbeats [8];
    int          mnb = 0;
    bit          mpend = 0;
    bit          mrdy;
    logic [71:0] mpvec = '0;
    bit          mov = 0;
    logic [71:0] mod = '0;
    bit          chk_en = 0;
    bit          rand_rdy = 0;

    idct_1d_mac dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_coef  (in_coef),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void build_table();
        real pi = 3.14159265358979;
        real c;
        real v;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                c = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                v = 128.0 * c * $cos(real'((2 * n + 1) * k) * pi / 16.0);
                itab[k][n] = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
            end
        end
    endfunction

    function automatic logic [71:0] ref_vec(input int f [8]);
        logic [71:0] v;
        real         s;
        int          r;
        v = '0;
        for (int n = 0; n < 8; n++) begin
            s = 0.0;
            for (int k = 0; k < 8; k++) begin
                s = s + real'(itab[k][n]) * real'(f[k]);
            end
            r = $rtoi($floor((s + 64.0) / 128.0));
            if (r > 255) r = 255;
            if (r < -256) r = -256;
            v[n*9 +: 9] = 9'(r);
        end
        return v;
    endfunction

    // Model: a finished vector waits one cycle, then loads when the output is free
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            mnb   = 0;
            mpend = 0;
            mov   = 0;
            mod   = '0;
        end else begin
            mrdy = !mpend;
            if (mpend && (!mov || out_ready)) begin
                mov   = 1;
                mod   = mpvec;
                mpend = 0;
            end else if (mov && out_ready) begin
                mov = 0;
            end
            if (mrdy && in_valid) begin
                mbeats[mnb] = int'($signed(in_coef));
                mnb++;
                if (mnb == 8) begin
                    mpvec = ref_vec(mbeats);
                    mpend = 1;
                    mnb   = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("out_valid", int'(out_valid), int'(mov));
            chk_vec("out_data", out_data, mod);
            chk("in_ready", int'(in_ready), int'(!mpend));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic beat(input int v, input int gap);
        bit r;
        bit ok;
        ok = 0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_coef  = 12'(v);
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            r = in_ready;
            tick();
            if (r) ok = 1;
        end
        in_valid = 1'b0;
        last_acc = cyc;
        chk("beat_accept", int'(ok), 1);
    endtask

    task automatic run_vec(input int f [8], input int maxgap);
        for (int k = 0; k < 8; k++) begin
            beat(f[k], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic wait_out(output int lat);
        bit ok;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        lat = cyc - last_acc + 1;
        chk("out_valid_arrives", int'(ok), 1);
    endtask

    task automatic chk_lanes(input string nm, input int e [8]);
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("%s[%0d]", nm, n), int'($signed(out_data[n*9 +: 9])), e[n]);
        end
    endtask

    int f [8];
    int lat;
    logic [71:0] pv;
    int dc23 [8] = '{23, 23, 23, 23, 23, 23, 23, 23};
    int h1   [8] = '{63, 53, 36, 12, -12, -36, -53, -63};
    int sp   [8] = '{255, 255, 255, 255, 255, 255, 255, 255};
    int sn   [8] = '{-256, -256, -256, -256, -256, -256, -256, -256};

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_coef   = '0;
        out_ready = 1'b1;
        build_table();

        // Pin the model's table and arithmetic to hand-derived values
        chk("pin_c00", itab[0][0], 45);
        chk("pin_c10", itab[1][0], 63);
        chk("pin_c21", itab[2][1], 24);
        chk("pin_c52", itab[5][2], 12);
        chk("pin_c73", itab[7][3], -63);
        f  = '{64, 0, 0, 0, 0, 0, 0, 0};
        pv = ref_vec(f);
        chk("pin_dc", int'($signed(pv[26:18])), 23);
        f  = '{0, 128, 0, 0, 0, 0, 0, 0};
        pv = ref_vec(f);
        chk("pin_h1_x7", int'($signed(pv[71:63])), -63);

        repeat (3) tick();
        reset  = 1'b0;
        chk_en = 1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk_vec("rst_out_data", out_data, 72'd0);
        chk("rst_in_ready", int'(in_ready), 1);

        f = '{64, 0, 0, 0, 0, 0, 0, 0};
        run_vec(f, 0);
        wait_out(lat);
        chk("dc_latency", lat, 2);
        chk_lanes("dc", dc23);
        tick();

        f = '{0, 128, 0, 0, 0, 0, 0, 0};
        run_vec(f, 0);
        wait_out(lat);
        chk_lanes("harm1", h1);
        tick();

        f = '{2047, 0, 0, 0, 0, 0, 0, 0};
        run_vec(f, 0);
        wait_out(lat);
        chk_lanes("sat_pos", sp);
        tick();

        f = '{-2048, 0, 0, 0, 0, 0, 0, 0};
        run_vec(f, 1);
        wait_out(lat);
        chk_lanes("sat_neg", sn);
        tick();

        // Backpressure: two vectors into a stalled output
        out_ready = 1'b0;
        f = '{64, 0, 0, 0, 0, 0, 0, 0};
        run_vec(f, 0);
        f = '{0, 128, 0, 0, 0, 0, 0, 0};
        run_vec(f, 0);
        repeat (3) tick();
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_valid", int'(out_valid), 1);
        chk_lanes("bp_hold", dc23);
        out_ready = 1'b1;
        tick();
        chk("bp_valid_reload", int'(out_valid), 1);
        chk_lanes("bp_second", h1);
        tick();
        chk("bp_drained", int'(out_valid), 0);

        // Aborted partial vector must leave no residue
        for (int i = 0; i < 4; i++) beat(100, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        f = '{64, 0, 0, 0, 0, 0, 0, 0};
        run_vec(f, 2);
        wait_out(lat);
        chk_lanes("post_reset", dc23);
        tick();

        rand_rdy = 1;
        for (int v = 0; v < 40; v++) begin
            for (int k = 0; k < 8; k++) begin
                if (v % 2 == 0) f[k] = int'($urandom_range(0, 400)) - 200;
                else            f[k] = int'($urandom_range(0, 4095)) - 2048;
            end
            run_vec(f, (v % 3 == 0) ? 0 : 2);
        end
        rand_rdy  = 0;
        out_ready = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
